scurve_single_test: RTL and testbench

SCURVE_SINGLE_TEST -- requirements
Module: scurve_single_test

---
 rtl/scurve_single_test.sv | 117 +++++++++++
 tb/tb_scurve_single_test.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/scurve_single_test.sv
// scurve_single_test: injects CPT_Max test pulses, counts in-window triggers and writes both counts to a FIFO
module scurve_single_test #(
   parameter logic [15:0] PULSE_PERIOD = 16'd2000,
   parameter logic [15:0] PULSE_WIDTH  = 16'd20,
   parameter logic [15:0] TRIG_WINDOW  = 16'd400
) (
   input  logic        Clk,
   input  logic        reset_n,
   input  logic        Single_Test_Start,
   input  logic        Force_Stop,
   input  logic [15:0] CPT_Max,
   input  logic        Trigger_In,
   input  logic        SCurve_Data_fifo_full,
   output logic        CTest_Pulse,
   output logic        SCurve_Data_fifo_wr_en,
   output logic [15:0] SCurve_Data_fifo_wr_din,
   output logic        Single_Test_Done,
   output logic        Busy
);
   typedef enum logic [2:0] {IDLE, INJECT, WRITE_CPT, WRITE_TRIG, DONE} state_t;
   state_t state_q, state_d;
   logic [15:0] phase_q, phase_d, pulse_q, pulse_d, trig_q, trig_d, cpt_q, cpt_d, din_q, din_d;
   logic [15:0] pulse_inc;
   logic seen_q, seen_d, ctest_q, ctest_d, wr_q, wr_d, done_q, done_d, edge_q;
   logic [2:0] sync_q;
   assign pulse_inc = pulse_q + 16'd1;
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      pulse_d = pulse_q;
      trig_d  = trig_q;
      cpt_d   = cpt_q;
      seen_d  = seen_q;
      din_d   = din_q;
      wr_d    = 1'b0;
      done_d  = 1'b0;
      // one counted trigger per period; saturating
      if (edge_q && state_q == INJECT && phase_q < TRIG_WINDOW && !seen_q) begin
         trig_d = (trig_q == 16'hFFFF) ? trig_q : trig_q + 16'd1;
         seen_d = 1'b1;
      end
      case (state_q)
         IDLE: if (Single_Test_Start) begin
            cpt_d   = CPT_Max;
            phase_d = 16'd0;
            pulse_d = 16'd0;
            trig_d  = 16'd0;
            seen_d  = 1'b0;
            state_d = (CPT_Max == 16'd0) ? WRITE_CPT : INJECT;
         end
         INJECT: if (phase_q == PULSE_PERIOD - 16'd1) begin
            pulse_d = pulse_inc;
            if (pulse_inc == cpt_q) state_d = WRITE_CPT;
            else begin
               phase_d = 16'd0;
               seen_d  = 1'b0;
            end
         end else phase_d = phase_q + 16'd1;
         WRITE_CPT: if (!SCurve_Data_fifo_full) begin
            wr_d    = 1'b1;
            din_d   = pulse_q;
            state_d = WRITE_TRIG;
         end
         WRITE_TRIG: if (!SCurve_Data_fifo_full) begin
            wr_d    = 1'b1;
            din_d   = trig_q;
            state_d = DONE;
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (Force_Stop) begin
         state_d = IDLE;
         wr_d    = 1'b0;
         done_d  = 1'b0;
         din_d   = din_q;
      end
      ctest_d = (state_d == INJECT) && (phase_d < PULSE_WIDTH);
   end
   always_ff @(posedge Clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         phase_q <= 16'd0;
         pulse_q <= 16'd0;
         trig_q  <= 16'd0;
         cpt_q   <= 16'd0;
         din_q   <= 16'd0;
         seen_q  <= 1'b0;
         ctest_q <= 1'b0;
         wr_q    <= 1'b0;
         done_q  <= 1'b0;
         sync_q  <= 3'd0;
         edge_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         pulse_q <= pulse_d;
         trig_q  <= trig_d;
         cpt_q   <= cpt_d;
         din_q   <= din_d;
         seen_q  <= seen_d;
         ctest_q <= ctest_d;
         wr_q    <= wr_d;
         done_q  <= done_d;
         sync_q  <= {sync_q[1:0], Trigger_In};
         edge_q  <= sync_q[1] & ~sync_q[2];
      end
   end
   assign CTest_Pulse             = ctest_q;
   assign SCurve_Data_fifo_wr_en  = wr_q;
   assign SCurve_Data_fifo_wr_din = din_q;
   assign Single_Test_Done        = done_q;
   assign Busy                    = (state_q != IDLE);
endmodule

// File: tb/tb_scurve_single_test.sv
// tb_scurve_single_test: scoreboard bench for scurve_single_test with a short injection period
module tb_scurve_single_test;
   logic        Clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        Single_Test_Start = 1'b0;
   logic        Force_Stop = 1'b0;
   logic [15:0] CPT_Max = 16'd0;
   logic        Trigger_In = 1'b0;
   logic        SCurve_Data_fifo_full = 1'b0;
   logic        CTest_Pulse, SCurve_Data_fifo_wr_en, Single_Test_Done, Busy;
   logic [15:0] SCurve_Data_fifo_wr_din;
   int tests = 0, fails = 0;
   int wr_cnt = 0, done_cnt = 0, rises = 0;
   int trig_mode = 0;
   int exp_q[$];
   scurve_single_test #(.PULSE_PERIOD(16'd100), .PULSE_WIDTH(16'd10), .TRIG_WINDOW(16'd40)) dut (
      .Clk(Clk), .reset_n(reset_n), .Single_Test_Start(Single_Test_Start), .Force_Stop(Force_Stop),
      .CPT_Max(CPT_Max), .Trigger_In(Trigger_In), .SCurve_Data_fifo_full(SCurve_Data_fifo_full),
      .CTest_Pulse(CTest_Pulse), .SCurve_Data_fifo_wr_en(SCurve_Data_fifo_wr_en),
      .SCurve_Data_fifo_wr_din(SCurve_Data_fifo_wr_din), .Single_Test_Done(Single_Test_Done), .Busy(Busy)
   );
   always #5 Clk = ~Clk;
   task automatic check(input string tag, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) begin
         @(negedge Clk);
         #1;
      end
   endtask
   // FIFO scoreboard, done counter and pulse shape monitor
   initial begin
      int hi = 0, since = 0;
      logic prev = 1'b0;
      forever begin
         @(negedge Clk);
         if (SCurve_Data_fifo_wr_en) begin
            wr_cnt++;
            if (exp_q.size() == 0) check("wr_unexpected", int'(SCurve_Data_fifo_wr_din), -1);
            else check("wr_din", int'(SCurve_Data_fifo_wr_din), exp_q.pop_front());
         end
         if (Single_Test_Done) done_cnt++;
         since++;
         if (CTest_Pulse && !prev) begin
            if (rises > 0) check("ctest_gap", since, 100);
            rises++;
            since = 0;
         end
         if (CTest_Pulse) hi++;
         else if (prev) begin
            check("ctest_width", hi, 10);
            hi = 0;
         end
         prev = CTest_Pulse;
      end
   end
   // trigger driver, offsets measured from each CTest_Pulse rise
   initial begin
      int ph = 0, per = 0;
      logic prev = 1'b0;
      forever begin
         @(negedge Clk);
         if (!Busy) per = 0;
         if (CTest_Pulse && !prev) begin
            ph = 0;
            per++;
         end else ph++;
         prev = CTest_Pulse;
         Trigger_In = (trig_mode == 1 && ph >= 20 && ph <= 22) ||
                      (trig_mode == 2 && ((ph >= 60 && ph <= 62) ||
                       (per == 2 && ((ph >= 5 && ph <= 7) || (ph >= 15 && ph <= 17)))));
      end
   end
   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
   task automatic start(input int cpt);
      rises = 0;
      CPT_Max = 16'(cpt);
      Single_Test_Start = 1'b1;
      tick(1);
      Single_Test_Start = 1'b0;
   endtask
   task automatic wait_done(input int d0, input int budget);
      for (int i = 0; i < budget && done_cnt == d0; i++) tick(1);
      check("done_pulse", done_cnt - d0, 1);
   endtask
   task automatic run_test(input int cpt, input int exp_trig, input int mode);
      int d0;
      trig_mode = mode;
      exp_q.push_back(cpt);
      exp_q.push_back(exp_trig);
      d0 = done_cnt;
      start(cpt);
      check("busy_after_start", Busy, 1);
      wait_done(d0, cpt * 100 + 50);
      tick(3);
      check("ctest_count", rises, cpt);
      check("done_single", done_cnt - d0, 1);
      check("sb_drained", exp_q.size(), 0);
      check("idle_after", Busy, 0);
      trig_mode = 0;
   endtask
   initial begin
      int d0, w0;
      tick(3);
      check("rst_ctest", CTest_Pulse, 0);
      check("rst_wr_en", SCurve_Data_fifo_wr_en, 0);
      check("rst_wr_din", int'(SCurve_Data_fifo_wr_din), 0);
      check("rst_done", Single_Test_Done, 0);
      check("rst_busy", Busy, 0);
      reset_n = 1'b1;
      tick(2);
      run_test(5, 5, 1);
      run_test(4, 1, 2);
      // zero injections: both words immediately
      exp_q.push_back(0);
      exp_q.push_back(0);
      d0 = done_cnt;
      start(0);
      wait_done(d0, 4);
      tick(2);
      check("zero_ctest", rises, 0);
      check("zero_sb", exp_q.size(), 0);
      // FIFO full across the end of the test
      trig_mode = 1;
      exp_q.push_back(3);
      exp_q.push_back(3);
      d0 = done_cnt;
      w0 = wr_cnt;
      start(3);
      tick(250);
      SCurve_Data_fifo_full = 1'b1;
      tick(100);
      check("full_no_wr", wr_cnt - w0, 0);
      check("full_no_done", done_cnt - d0, 0);
      check("full_busy", Busy, 1);
      SCurve_Data_fifo_full = 1'b0;
      wait_done(d0, 20);
      check("full_words", wr_cnt - w0, 2);
      check("full_sb", exp_q.size(), 0);
      // abort in the second period, then a fresh short test
      tick(2);
      d0 = done_cnt;
      w0 = wr_cnt;
      start(5);
      tick(150);
      Force_Stop = 1'b1;
      Single_Test_Start = 1'b1;
      tick(1);
      Force_Stop = 1'b0;
      Single_Test_Start = 1'b0;
      check("abort_busy", Busy, 0);
      check("abort_ctest", CTest_Pulse, 0);
      tick(20);
      check("abort_no_wr", wr_cnt - w0, 0);
      check("abort_no_done", done_cnt - d0, 0);
      run_test(2, 2, 1);
      // reset while the second word is pending
      exp_q.push_back(1);
      d0 = done_cnt;
      w0 = wr_cnt;
      start(1);
      for (int i = 0; i < 150 && wr_cnt == w0; i++) tick(1);
      check("rst_first_word", wr_cnt - w0, 1);
      reset_n = 1'b0;
      tick(1);
      check("midrst_wr_en", SCurve_Data_fifo_wr_en, 0);
      check("midrst_wr_din", int'(SCurve_Data_fifo_wr_din), 0);
      check("midrst_busy", Busy, 0);
      check("midrst_done", Single_Test_Done, 0);
      tick(2);
      reset_n = 1'b1;
      tick(10);
      check("midrst_one_word", wr_cnt - w0, 1);
      check("midrst_no_done", done_cnt - d0, 0);
      check("midrst_sb", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
